// File: rtl/dds_gen_core.sv
// Multi-waveform DDS core: shadowed phase accumulator with linear sweep, external
// 1-cycle sine ROM, square/triangle/sawtooth synthesis and amplitude scaling.
module dds_gen_core #(
    parameter int ACC_W       = 32,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 10,
    parameter int AMP_W       = 8,
    parameter int SWEEP_DIV_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   cfg_load,
    input  logic                   phase_clr,
    input  logic [ACC_W-1:0]       fword_in,
    input  logic [ADDR_W-1:0]      pword_in,
    input  logic [1:0]             mode_in,
    input  logic [AMP_W-1:0]       amp_in,
    input  logic                   sweep_en_in,
    input  logic [ACC_W-1:0]       sweep_step_in,
    input  logic [ACC_W-1:0]       sweep_stop_in,
    input  logic [SWEEP_DIV_W-1:0] sweep_dwell_in,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [DATA_W-1:0]      rom_q,
    output logic                   da_clk,
    output logic [DATA_W-1:0]      da_data,
    output logic                   sync,
    output logic                   sweep_wrap
);

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SAW    = 2'd3
    } mode_e;

    localparam int TRI_W = ADDR_W - 1;
    localparam int PW    = DATA_W + AMP_W + 2;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    logic [ACC_W-1:0]       fword_q, fword_d;
    logic [ACC_W-1:0]       start_q, start_d;
    logic [ACC_W-1:0]       step_q, step_d;
    logic [ACC_W-1:0]       stop_q, stop_d;
    logic [ADDR_W-1:0]      pword_q, pword_d;
    mode_e                  mode_q, mode_d;
    logic [AMP_W-1:0]       amp_q, amp_d;
    logic                   sweep_en_q, sweep_en_d;
    logic [SWEEP_DIV_W-1:0] dwell_q, dwell_d;
    logic [SWEEP_DIV_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic                   wrap_q, wrap_d;
    logic                   sweep_wrap_q, sweep_wrap_d;
    logic [ADDR_W-1:0]      phase_q, phase_d;
    logic [ADDR_W-1:0]      phase2_q, phase2_d;
    logic [DATA_W-1:0]      wave_q, wave_d;
    logic [DATA_W-1:0]      da_data_q, da_data_d;
    logic [2:0]             sync_pipe_q, sync_pipe_d;
    logic                   sync_q, sync_d;

    logic [ACC_W:0]         acc_sum;
    logic [ACC_W:0]         sweep_sum;
    logic [TRI_W-1:0]       tri_fold;
    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   prod;

    // Accumulator, sweep stepping and config shadowing; cfg_load overrides a sweep step.
    always_comb begin
        fword_d      = fword_q;
        start_d      = start_q;
        step_d       = step_q;
        stop_d       = stop_q;
        pword_d      = pword_q;
        mode_d       = mode_q;
        amp_d        = amp_q;
        sweep_en_d   = sweep_en_q;
        dwell_d      = dwell_q;
        acc_d        = acc_q;
        wrap_d       = wrap_q;
        dwell_cnt_d  = dwell_cnt_q;
        sweep_wrap_d = 1'b0;
        acc_sum      = {1'b0, acc_q} + {1'b0, fword_q};
        sweep_sum    = {1'b0, fword_q} + {1'b0, step_q};

        if (!en) begin
            acc_d       = '0;
            wrap_d      = 1'b0;
            dwell_cnt_d = '0;
        end else begin
            if (cfg_load && phase_clr) begin
                acc_d  = '0;
                wrap_d = 1'b0;
            end else begin
                acc_d  = acc_sum[ACC_W-1:0];
                wrap_d = acc_sum[ACC_W];
            end
            if (cfg_load) begin
                dwell_cnt_d = '0;
            end else if (sweep_en_q) begin
                if (dwell_cnt_q == dwell_q) begin
                    dwell_cnt_d = '0;
                    if (sweep_sum > {1'b0, stop_q}) begin
                        fword_d      = start_q;
                        sweep_wrap_d = 1'b1;
                    end else begin
                        fword_d = sweep_sum[ACC_W-1:0];
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + SWEEP_DIV_W'(1);
                end
            end
        end

        if (cfg_load) begin
            fword_d    = fword_in;
            start_d    = fword_in;
            step_d     = sweep_step_in;
            stop_d     = sweep_stop_in;
            pword_d    = pword_in;
            mode_d     = mode_e'(mode_in);
            amp_d      = amp_in;
            sweep_en_d = sweep_en_in;
            dwell_d    = sweep_dwell_in;
        end
    end

    // Four-stage sample pipeline: phase, ROM wait, waveform select, amplitude scale.
    always_comb begin
        phase_d     = acc_q[ACC_W-1 -: ADDR_W] + pword_q;
        phase2_d    = phase_q;
        tri_fold    = phase2_q[ADDR_W-1] ? ~phase2_q[TRI_W-1:0] : phase2_q[TRI_W-1:0];
        wave_d      = rom_q;
        case (mode_q)
            MODE_SINE:   wave_d = rom_q;
            MODE_SQUARE: wave_d = phase2_q[ADDR_W-1] ? '0 : '1;
            MODE_TRI:    wave_d = DATA_W'({tri_fold, {DATA_W{1'b0}}} >> TRI_W);
            MODE_SAW:    wave_d = DATA_W'({phase2_q, {DATA_W{1'b0}}} >> ADDR_W);
            default:     wave_d = rom_q;
        endcase
        diff = $signed({1'b0, wave_q}) - $signed({1'b0, MID});
        prod = PW'(diff) * PW'($signed({1'b0, amp_q}));
        if (&amp_q) begin
            da_data_d = wave_q;
        end else begin
            da_data_d = MID + DATA_W'(prod >>> AMP_W);
        end
        sync_pipe_d = {sync_pipe_q[1:0], wrap_q};
        sync_d      = sync_pipe_q[2];

        if (!en) begin
            phase_d     = '0;
            phase2_d    = '0;
            wave_d      = '0;
            da_data_d   = MID;
            sync_pipe_d = '0;
            sync_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fword_q      <= '0;
            start_q      <= '0;
            step_q       <= '0;
            stop_q       <= '0;
            pword_q      <= '0;
            mode_q       <= MODE_SINE;
            amp_q        <= '0;
            sweep_en_q   <= 1'b0;
            dwell_q      <= '0;
            dwell_cnt_q  <= '0;
            acc_q        <= '0;
            wrap_q       <= 1'b0;
            sweep_wrap_q <= 1'b0;
            phase_q      <= '0;
            phase2_q     <= '0;
            wave_q       <= '0;
            da_data_q    <= '0;
            sync_pipe_q  <= '0;
            sync_q       <= 1'b0;
        end else begin
            fword_q      <= fword_d;
            start_q      <= start_d;
            step_q       <= step_d;
            stop_q       <= stop_d;
            pword_q      <= pword_d;
            mode_q       <= mode_d;
            amp_q        <= amp_d;
            sweep_en_q   <= sweep_en_d;
            dwell_q      <= dwell_d;
            dwell_cnt_q  <= dwell_cnt_d;
            acc_q        <= acc_d;
            wrap_q       <= wrap_d;
            sweep_wrap_q <= sweep_wrap_d;
            phase_q      <= phase_d;
            phase2_q     <= phase2_d;
            wave_q       <= wave_d;
            da_data_q    <= da_data_d;
            sync_pipe_q  <= sync_pipe_d;
            sync_q       <= sync_d;
        end
    end

    // The converter clock is gated combinationally so it parks high while disabled.
    assign da_clk     = en ? clk : 1'b1;
    assign rom_addr   = phase_q;
    assign da_data    = da_data_q;
    assign sync       = sync_q;
    assign sweep_wrap = sweep_wrap_q;

endmodule

// File: doc/dds_gen_core.md
Name: dds_gen_core

Overview:
Parametrised multi-waveform DDS core for the scope/signal-generator path. A phase accumulator with shadowed configuration drives an external synchronous sine ROM (1-cycle read latency). It synthesises sine, square, triangle or sawtooth and applies amplitude scaling. An optional linear frequency sweep is built in. Output is offset-binary samples for the DA converter, plus a cycle-sync pulse.

Parameters:
ACC_W, 32, phase accumulator and frequency word width
ADDR_W, 12, phase/ROM address width (accumulator MSBs used)
DATA_W, 10, sample width (offset binary)
AMP_W, 8, amplitude word width
SWEEP_DIV_W, 16, width of sweep dwell counter

Ports:
clk  in  1  system/sample clock
rst  in  1  asynchronous reset, active-low
en  in  1  run enable; low clears accumulator and pipeline
cfg_load  in  1  one-cycle strobe: copy *_in words into active registers
phase_clr  in  1  qualified by cfg_load: also zero accumulator
fword_in  in  ACC_W  frequency word (sweep start value)
pword_in  in  ADDR_W  phase offset
mode_in  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth
amp_in  in  AMP_W  amplitude; all-ones = unity
sweep_en_in  in  1  enable sweep
sweep_step_in  in  ACC_W  fword increment per dwell
sweep_stop_in  in  ACC_W  sweep end fword
sweep_dwell_in  in  SWEEP_DIV_W  cycles per step minus 1
rom_addr  out  ADDR_W  registered address to sine ROM
rom_q  in  DATA_W  sine ROM data, valid one cycle after rom_addr
da_clk  out  1  clk when en=1, else constant 1
da_data  out  DATA_W  output sample
sync  out  1  one-cycle pulse on accumulator wrap, aligned with da_data
sweep_wrap  out  1  one-cycle pulse when sweep returns to start

Behaviour:
- Reset: all registers 0. rom_addr=0, da_data=0, sync=0, sweep_wrap=0. Active config zero (mode sine, amp 0, sweep off).
- Config: on cycle with cfg_load=1 every active register (fword, start, pword, mode, amp, sweep fields) takes its *_in at the next edge. Accumulator uses new fword from the following cycle. cfg_load is honoured even when en=0.
- phase_clr with cfg_load: acc<=0 at same edge (overrides increment).
- en=0: acc, dwell counter, pipeline stages, sync pipe cleared to 0. da_data held at 2^(DATA_W-1) (mid-scale). Active config retained.
- Accumulator: acc<=acc+fword mod 2^ACC_W. carry-out flags wrap.
- Stage1: phase<=acc[ACC_W-1 -: ADDR_W]+pword mod 2^ADDR_W. rom_addr=phase.
- Stage2 (ROM cycle): phase_d<=phase.
- Stage3: wave<= mode 0 rom_q. mode 1: all-ones if phase_d MSB=0 else 0. mode 2: triangle from phase_d (rising 0..max in first half, falling in second, MSB-folded, scaled to DATA_W). mode 3: phase_d MSBs zero-extended/truncated to DATA_W.
- Stage4: amp all-ones: da_data<=wave. Else da_data<=MID+(((wave-MID)*amp)>>>AMP_W), signed arithmetic, MID=2^(DATA_W-1). Result always in range; no saturation required.
- Latency: acc value at edge N appears in da_data after edge N+4. sync delayed by the same 4 stages.
- Sweep (active sweep_en=1, en=1): dwell counter counts 0..sweep_dwell. At terminal count fword<=fword+step. If that sum > stop or overflows ACC_W, fword<=start instead and sweep_wrap pulses 1 cycle. cfg_load during sweep restarts: fword=start, dwell=0. sweep_en=0: fword constant.
- Simultaneous cfg_load and sweep terminal count: cfg_load wins.
- Reset mid-operation: immediate clear, no glitch requirement on da_clk beyond combinational gating.

Test Plan:
- Reset then cfg_load fword=2^20, pword=0, mode 0, amp=FF, en=1 -> rom_addr sequence 0,1,2,... after 2 cycles. da_data=rom_q delayed per 4-cycle latency. sync every 4096 cycles.
- mode 1, fword=2^23 (period 512 cycles) -> da_data 1023 for 256 cycles, 0 for 256. Change pword_in=2048 with cfg_load -> 180° shift (level inverts).
- mode 2/3, amp=0x80, DATA_W=10 -> sawtooth spans 256..767 (half swing about 512). amp=0 -> constant 512.
- Sweep start=2^20, step=2^20, stop=2^22, dwell=9 -> fword increments every 10 cycles: 2^20,2*2^20,3*2^20,4*2^20. Next step exceeds stop -> back to 2^20 with one sweep_wrap pulse.
- en dropped mid-run -> next cycle da_data=512, rom_addr=0 after flush, da_clk=1. Re-enable restarts phase from 0 with retained config.
- Async rst asserted mid-sweep between clock edges -> all outputs 0 immediately. cfg_load + sweep terminal count same cycle -> fword=start, no sweep_wrap.
